// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program-memory loader.
// Stream: count byte N at COUNT_BYTE_POS, then N words, each high byte then low byte.
package prog_loader_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned INSTR_W        = 16;
  localparam int unsigned COUNT_BYTE_POS = 0;

  typedef enum logic [2:0] {
    HDR,
    HI,
    LO,
    CSUM,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write bus of the loader.
//   in_data/in_valid/in_ready : valid/ready byte stream into the loader
//   mem_we/mem_addr/mem_wdata : one-cycle write strobe with address and word
// slave = loader side, master = stream source / memory side.
interface prog_loader_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 16
);
  import prog_loader_pkg::*;

  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/prog_loader_csum.sv
// Running XOR accumulator over the data bytes of a load.
//   clk, rstn : clock, async active-low reset
//   clr       : zero the accumulator (wins over en)
//   en        : fold din into the accumulator
//   acc       : current XOR of all folded bytes
module prog_loader_csum
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              en,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] acc
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc ^ din;
  end

endmodule

// File: rtl/prog_loader.sv
// Fills a writable program memory from a byte stream and holds the core in
// reset until the load completes cleanly.
//   clk, rstn  : clock, async active-low reset
//   load_req   : one-cycle pulse, starts or restarts a load
//   bus        : byte stream in, program-memory write strobe out
//   core_rstn  : 0 keeps the processor core in reset
//   load_done  : load finished successfully (level)
//   load_err   : load failed (level)
// Optional: define PROG_LOADER_CSUM_EN to require a trailing XOR checksum byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load_req,
  prog_loader_if.slave  bus,
  output logic          core_rstn,
  output logic          load_done,
  output logic          load_err
);

`ifdef PROG_LOADER_CSUM_EN
  localparam state_t POST_DATA = CSUM;
`else
  localparam state_t POST_DATA = DONE;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [BYTE_W-1:0] rem_q, rem_d;
  logic [BYTE_W-1:0] hold_q, hold_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              in_ready_c;
  logic              accept_c;

  // Ready only in byte-consuming states; a restart request masks it.
`ifdef PROG_LOADER_CSUM_EN
  assign in_ready_c = (state_q inside {HDR, HI, LO, CSUM}) && !load_req;
`else
  assign in_ready_c = (state_q inside {HDR, HI, LO}) && !load_req;
`endif
  assign accept_c = in_ready_c && bus.in_valid;

`ifdef PROG_LOADER_CSUM_EN
  logic [BYTE_W-1:0] csum_acc;
  logic              csum_clr_c;
  logic              csum_en_c;

  // Count byte is never folded: accumulator is held clear while in HDR.
  assign csum_clr_c = load_req || (state_q == HDR);
  assign csum_en_c  = accept_c && (state_q inside {HI, LO});

  prog_loader_csum u_csum (
    .clk  (clk),
    .rstn (rstn),
    .clr  (csum_clr_c),
    .en   (csum_en_c),
    .din  (bus.in_data),
    .acc  (csum_acc)
  );
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    hold_d      = hold_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      HDR: begin
        if (accept_c) begin
          if (bus.in_data == '0) begin
            state_d = POST_DATA;
          end else if (bus.in_data > BYTE_W'(DEPTH)) begin
            state_d = ERR;
          end else begin
            rem_d   = bus.in_data;
            state_d = HI;
          end
        end
      end
      HI: begin
        if (accept_c) begin
          hold_d  = bus.in_data;
          state_d = LO;
        end
      end
      LO: begin
        if (accept_c) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = idx_q;
          mem_wdata_d = DATA_W'({hold_q, bus.in_data});
          idx_d       = idx_q + ADDR_W'(1);
          rem_d       = rem_q - BYTE_W'(1);
          state_d     = (rem_q == BYTE_W'(1)) ? POST_DATA : HI;
        end
      end
`ifdef PROG_LOADER_CSUM_EN
      CSUM: begin
        if (accept_c) state_d = (bus.in_data == csum_acc) ? DONE : ERR;
      end
`endif
      DONE:    done_d  = 1'b1;
      ERR:     err_d   = 1'b1;
      default: state_d = HDR;
    endcase

    // Restart drops any half-assembled word; no byte is taken this cycle.
    if (load_req) begin
      state_d  = HDR;
      idx_d    = '0;
      rem_d    = '0;
      mem_we_d = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= HDR;
      idx_q       <= '0;
      rem_q       <= '0;
      hold_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      hold_q      <= hold_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign core_rstn     = done_q;
  assign load_done     = done_q;
  assign load_err      = err_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 16;
`ifdef PROG_LOADER_CSUM_EN
  localparam int EXP_WRITES = 24;
`else
  localparam int EXP_WRITES = 22;
`endif

  logic clk      = 1'b0;
  logic rstn     = 1'b0;
  logic load_req = 1'b0;
  logic core_rstn, load_done, load_err;

  prog_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .load_req  (load_req),
    .bus       (bus),
    .core_rstn (core_rstn),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  total  = 0;
  int  bad    = 0;
  int  wr_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("we_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("we_addr", 32'(bus.mem_addr), 32'(mon_e.addr));
        check("we_data", 32'(bus.mem_wdata), 32'(mon_e.data));
      end
    end
  end

  task automatic push_wr(input int a, input logic [15:0] d);
    wr_t w;
    w.addr = ADDR_W'(a);
    w.data = d;
    exp_q.push_back(w);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    bit rdy;
    int n;
    n = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 200);
    if (!rdy) check("send_timeout", 32'd0, 32'd1);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_req();
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
  endtask

  // sel 0 waits for load_done, sel 1 for load_err.
  task automatic wait_flag(input string tag, input int sel);
    logic f;
    f = 1'b0;
    for (int i = 0; i < 50 && f !== 1'b1; i++) begin
      @(negedge clk);
      f = (sel == 0) ? load_done : load_err;
    end
    check(tag, 32'(f), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_data  = '0;
    bus.in_valid = 1'b0;

    // Reset values
    #12;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_core_rstn", 32'(core_rstn), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(load_err), 32'd0);
    #6 rstn = 1'b1;
    @(posedge clk);
    #1;

    // Basic back-to-back load
    push_wr(0, 16'h0A02);
    push_wr(1, 16'h4B00);
    send_byte(8'h02);
    send_byte(8'h0A);
    send_byte(8'h02);
    send_byte(8'h4B);
    send_byte(8'h00);
`ifdef PROG_LOADER_CSUM_EN
    send_byte(8'h43);
`endif
    @(negedge clk);
    check("basic_done_lat", 32'(load_done), 32'd0);
    check("basic_core_lat", 32'(core_rstn), 32'd0);
    @(negedge clk);
    check("basic_done", 32'(load_done), 32'd1);
    check("basic_core", 32'(core_rstn), 32'd1);
    check("basic_ready_lo", 32'(bus.in_ready), 32'd0);
    check("basic_q_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;

    // Empty count
    pulse_req();
    @(negedge clk);
    check("req_clr_done", 32'(load_done), 32'd0);
    check("req_clr_core", 32'(core_rstn), 32'd0);
    @(posedge clk);
    #1;
    send_byte(8'h00);
`ifdef PROG_LOADER_CSUM_EN
    send_byte(8'h00);
`endif
    wait_flag("empty_done", 0);

    // Oversize count
    pulse_req();
    send_byte(8'h11);
    wait_flag("over_err", 1);
    check("over_core", 32'(core_rstn), 32'd0);
    check("over_ready", 32'(bus.in_ready), 32'd0);
    check("over_done", 32'(load_done), 32'd0);

    // Full load with random stalls
    pulse_req();
    check("err_cleared", 32'(load_err), 32'd0);
    send_byte(8'h10);
    for (int w = 0; w < 16; w++) begin
      push_wr(w, 16'h3C00);
      gap($urandom_range(0, 2));
      send_byte(8'h3C);
      gap($urandom_range(0, 2));
      send_byte(8'h00);
    end
`ifdef PROG_LOADER_CSUM_EN
    send_byte(8'h00);
`endif
    wait_flag("full_done", 0);
    check("full_q_empty", 32'(exp_q.size()), 32'd0);
    bus.in_data  = 8'h5A;
    bus.in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("full_ignore_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    check("full_still_done", 32'(load_done), 32'd1);

    // Mid-load restart
    pulse_req();
    push_wr(0, 16'h1122);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    bus.in_data  = 8'h44;
    bus.in_valid = 1'b1;
    load_req     = 1'b1;
    @(negedge clk);
    check("req_masks_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    load_req     = 1'b0;
    bus.in_valid = 1'b0;
    gap(3);
    check("restart_q_empty", 32'(exp_q.size()), 32'd0);
    check("restart_ready", 32'(bus.in_ready), 32'd1);
    push_wr(0, 16'hABCD);
    send_byte(8'h01);
    send_byte(8'hAB);
    send_byte(8'hCD);
`ifdef PROG_LOADER_CSUM_EN
    send_byte(8'h66);
`endif
    wait_flag("restart_done", 0);

    // Reset between HI and LO bytes
    pulse_req();
    push_wr(0, 16'h0102);
    push_wr(1, 16'h0304);
    send_byte(8'h03);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h05);
    #2 rstn = 1'b0;
    #1;
    check("arst_addr", 32'(bus.mem_addr), 32'd0);
    check("arst_wdata", 32'(bus.mem_wdata), 32'd0);
    check("arst_we", 32'(bus.mem_we), 32'd0);
    check("arst_ready", 32'(bus.in_ready), 32'd1);
    check("arst_done", 32'(load_done), 32'd0);
    check("arst_core", 32'(core_rstn), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    gap(3);
    check("arst_q_empty", 32'(exp_q.size()), 32'd0);

`ifdef PROG_LOADER_CSUM_EN
    // Checksum match and mismatch
    push_wr(0, 16'h1234);
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h26);
    wait_flag("csum_ok_done", 0);
    pulse_req();
    push_wr(0, 16'h1234);
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h00);
    wait_flag("csum_bad_err", 1);
    check("csum_bad_core", 32'(core_rstn), 32'd0);
`endif

    gap(3);
    check("write_count", 32'(wr_cnt), 32'(EXP_WRITES));
    check("final_q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
